// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell and a carry
// flip-flop process one operand bit per clock, LSB first, under start/busy/done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sr_reg, a_sr_next;
    logic [WIDTH-1:0] b_sr_reg, b_sr_next;
    logic [WIDTH-1:0] res_sr_reg, res_sr_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    logic [WIDTH-1:0] b_load;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;
    logic             accept;

    // Subtraction is a + ~b + 1: B is inverted on load and the +1 enters as carry-in.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bload
            assign b_load[gi] = b[gi] ^ sub;
        end
    endgenerate

    assign fa_s     = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
    assign fa_c     = (a_sr_reg[0] & b_sr_reg[0]) | (carry_reg & (a_sr_reg[0] ^ b_sr_reg[0]));
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));
    // The DONE cycle doubles as an accept slot so back-to-back ops run every WIDTH+1 clocks.
    assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));

    always_comb begin
        state_next  = state_reg;
        a_sr_next   = a_sr_reg;
        b_sr_next   = b_sr_reg;
        res_sr_next = res_sr_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        sum_next    = sum_reg;
        cout_next   = cout_reg;
        ovf_next    = ovf_reg;

        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
            end
            SHIFT: begin
                a_sr_next   = a_sr_reg >> 1;
                b_sr_next   = b_sr_reg >> 1;
                res_sr_next = {fa_s, res_sr_reg[WIDTH-1:1]};
                carry_next  = fa_c;
                cnt_next    = cnt_reg + 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    cnt_next   = '0;
                    sum_next   = {fa_s, res_sr_reg[WIDTH-1:1]};
                    cout_next  = fa_c;
                    // carry_reg still holds the carry into the MSB here
                    ovf_next   = carry_reg ^ fa_c;
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase

        if (accept) begin
            state_next  = SHIFT;
            a_sr_next   = a;
            b_sr_next   = b_load;
            res_sr_next = '0;
            carry_next  = sub;
            cnt_next    = '0;
            busy_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sr_reg   <= a_sr_next;
            b_sr_reg   <= b_sr_next;
            res_sr_reg <= res_sr_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            sum_reg    <= sum_next;
            cout_reg   <= cout_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign sum       = sum_reg;
    assign carry_out = cout_reg;
    assign overflow  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 3 and 16: stimulus pushes expected
// results, per-instance monitors pop and compare on every done pulse.
module tb_serial_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    exp_t q8[$];
    exp_t q3[$];
    exp_t q16[$];
    int   n_done8 = 0, n_done3 = 0, n_done16 = 0;
    int   exp_done8 = 0, exp_done3 = 0, exp_done16 = 0;
    logic [7:0] prev_sum8 = 8'h00;

    logic        rst_n8, rst_nx;
    logic        start8, sub8, start3, sub3, start16, sub16;
    logic [7:0]  a8, b8;
    logic [2:0]  a3, b3;
    logic [15:0] a16, b16;
    logic        busy8, done8, cout8, ovf8;
    logic        busy3, done3, cout3, ovf3;
    logic        busy16, done16, cout16, ovf16;
    logic [7:0]  sum8;
    logic [2:0]  sum3;
    logic [15:0] sum16;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8), .overflow(ovf8)
    );
    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_nx), .start(start3), .sub(sub3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .sum(sum3), .carry_out(cout3), .overflow(ovf3)
    );
    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_nx), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .carry_out(cout16), .overflow(ovf16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic on wide integers, independent of the bit-serial datapath.
    task automatic ref_op(input int w, input bit [63:0] av, input bit [63:0] bv, input bit sv,
                          output logic [31:0] s, output logic c, output logic o);
        bit [63:0] mask, bb, full;
        mask = (64'd1 << w) - 64'd1;
        bb   = sv ? (~bv & mask) : bv;
        full = av + bb + 64'(sv);
        s    = 32'(full & mask);
        c    = full[w];
        o    = (av[w-1] == bb[w-1]) && (full[w-1] != av[w-1]);
    endtask

    task automatic push8(input logic [7:0] es, input logic ec, input logic eo, input string nm);
        exp_t e;
        e.sum = 32'(es); e.cout = ec; e.ovf = eo; e.cyc = cyc + 8; e.name = nm;
        q8.push_back(e);
        exp_done8++;
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       input logic [7:0] es, input logic ec, input logic eo,
                       input string nm, input bit inject);
        @(negedge clk);
        start8 = 1'b1; a8 = av; b8 = bv; sub8 = sv;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~av; b8 = ~bv; sub8 = ~sv;
        push8(es, ec, eo, nm);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk({nm, "_busy"}, 64'(busy8), 64'(1'b1));
            chk({nm, "_hold"}, 64'(sum8), 64'(prev_sum8));
            if (inject && i == 2) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0;
            end else begin
                start8 = 1'b0;
            end
        end
        @(negedge clk);
        chk({nm, "_busy_end"}, 64'(busy8), 64'(1'b0));
        @(negedge clk);
        chk({nm, "_done_low"}, 64'(done8), 64'(1'b0));
        chk({nm, "_sum_kept"}, 64'(sum8), 64'(es));
        $display("[TB] w8 %s a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d", nm, av, bv, sv, sum8, cout8, ovf8);
        prev_sum8 = es;
    endtask

    // Monitors
    initial forever begin
        @(negedge clk);
        if (done8 === 1'b1) begin
            n_done8++;
            chk("w8_busy_done_excl", 64'(busy8), 64'(1'b0));
            if (q8.size() == 0) begin
                tests++; fails++;
                $display("FAIL w8_unexpected_done got done with sum=%h required no done", sum8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk({e.name, "_sum"},  64'(sum8),  64'(e.sum[7:0]));
                chk({e.name, "_cout"}, 64'(cout8), 64'(e.cout));
                chk({e.name, "_ovf"},  64'(ovf8),  64'(e.ovf));
                chk({e.name, "_lat"},  64'(cyc),   64'(e.cyc));
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done3 === 1'b1) begin
            n_done3++;
            chk("w3_busy_done_excl", 64'(busy3), 64'(1'b0));
            if (q3.size() == 0) begin
                tests++; fails++;
                $display("FAIL w3_unexpected_done got done with sum=%h required no done", sum3);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk({e.name, "_sum"},  64'(sum3),  64'(e.sum[2:0]));
                chk({e.name, "_cout"}, 64'(cout3), 64'(e.cout));
                chk({e.name, "_ovf"},  64'(ovf3),  64'(e.ovf));
                chk({e.name, "_lat"},  64'(cyc),   64'(e.cyc));
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done16 === 1'b1) begin
            n_done16++;
            chk("w16_busy_done_excl", 64'(busy16), 64'(1'b0));
            if (q16.size() == 0) begin
                tests++; fails++;
                $display("FAIL w16_unexpected_done got done with sum=%h required no done", sum16);
            end else begin
                exp_t e;
                e = q16.pop_front();
                chk({e.name, "_sum"},  64'(sum16),  64'(e.sum[15:0]));
                chk({e.name, "_cout"}, 64'(cout16), 64'(e.cout));
                chk({e.name, "_ovf"},  64'(ovf16),  64'(e.ovf));
                chk({e.name, "_lat"},  64'(cyc),    64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout at cycle %0d required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n8 = 1'b0; rst_nx = 1'b0;
        start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
        start3 = 0; sub3 = 0; a3 = 0; b3 = 0;
        start16 = 0; sub16 = 0; a16 = 0; b16 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy8), 64'(1'b0));
        chk("rst_done", 64'(done8), 64'(1'b0));
        chk("rst_sum",  64'(sum8),  64'(8'h00));
        chk("rst_cout", 64'(cout8), 64'(1'b0));
        chk("rst_ovf",  64'(ovf8),  64'(1'b0));
        chk("rst_sum16", 64'(sum16), 64'(16'h0000));
        rst_n8 = 1'b1; rst_nx = 1'b1;

        // WIDTH=8 directed vectors
        op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01", 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01", 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01", 1'b0);
        op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07", 1'b0);
        op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01", 1'b0);
        op8(8'h3C, 8'h12, 1'b0, 8'h4E, 1'b0, 1'b0, "add_inject", 1'b1);
        repeat (12) @(negedge clk);
        chk("inject_single_done", 64'(n_done8), 64'(exp_done8));

        // Reset at the 4th SHIFT edge
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n8 = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy8), 64'(1'b0));
        chk("abort_done", 64'(done8), 64'(1'b0));
        chk("abort_sum",  64'(sum8),  64'(8'h00));
        chk("abort_cout", 64'(cout8), 64'(1'b0));
        chk("abort_ovf",  64'(ovf8),  64'(1'b0));
        rst_n8 = 1'b1;
        prev_sum8 = 8'h00;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 64'(n_done8), 64'(exp_done8));
        $display("[TB] w8 abort at shift edge 4 -> sum=%h busy=%0d done=%0d", sum8, busy8, done8);
        op8(8'h64, 8'h32, 1'b1, 8'h32, 1'b1, 1'b0, "sub_after_abort", 1'b0);

        // WIDTH=3 exhaustive, start held high back-to-back
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 8; x++) begin
                for (int y = 0; y < 8; y++) begin
                    exp_t e;
                    @(negedge clk);
                    start3 = 1'b1; a3 = 3'(x); b3 = 3'(y); sub3 = s[0];
                    @(posedge clk); #1;
                    ref_op(3, 64'(x), 64'(y), s[0], e.sum, e.cout, e.ovf);
                    e.cyc = cyc + 3;
                    e.name = $sformatf("w3_%0d_%0d_%0d", s, x, y);
                    q3.push_back(e);
                    exp_done3++;
                    $display("[TB] w3 a=%0d b=%0d sub=%0d expect sum=%0d cout=%0d ovf=%0d",
                             x, y, s, e.sum, e.cout, e.ovf);
                    repeat (3) @(posedge clk);
                end
            end
        end
        @(negedge clk);
        start3 = 1'b0;

        // WIDTH=16
        @(negedge clk);
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 1'b0;
        @(posedge clk); #1;
        start16 = 1'b0;
        begin
            exp_t e;
            e.sum = 32'h0000; e.cout = 1'b1; e.ovf = 1'b0; e.cyc = cyc + 16; e.name = "w16_ffff_0001";
            q16.push_back(e);
            exp_done16++;
        end
        repeat (20) @(negedge clk);
        $display("[TB] w16 a=ffff b=0001 sub=0 -> sum=%h cout=%0d ovf=%0d", sum16, cout16, ovf16);

        repeat (8) @(negedge clk);
        chk("w8_queue_empty",  64'(q8.size()),  64'(0));
        chk("w3_queue_empty",  64'(q3.size()),  64'(0));
        chk("w16_queue_empty", 64'(q16.size()), 64'(0));
        chk("w8_done_count",   64'(n_done8),  64'(exp_done8));
        chk("w3_done_count",   64'(n_done3),  64'(exp_done3));
        chk("w16_done_count",  64'(n_done16), 64'(exp_done16));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
